// File: rtl/vga_dma.sv
// Video DMA responder: turns VGA word requests into memory-bus reads and
// returns each fetched frame-buffer word with a one-cycle vack strobe.
module vga_dma #(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE        = '0,
  parameter int                FRAME_WORDS = 16380
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vreq,
  input  logic              vreset,
  output logic              vack,
  output logic [15:0]       pixels_out,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [15:0]       mem_rdata,
  input  logic              ovr_clr,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST = BASE + ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, ACK} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              lat_vld;
  logic              lat_rst;

  logic              direct;
  logic              consume;
  logic              take;
  logic              fill;
  logic              drop;
  logic              fetch_rst;
  logic [ADDR_W-1:0] fetch_addr;

  // A request goes straight to the bus only from an idle, empty responder;
  // anything else passes through the one-deep latch.
  always_comb begin
    direct     = (state == IDLE) && !lat_vld && vreq;
    consume    = ((state == IDLE) || (state == ACK)) && lat_vld;
    take       = vreq && !direct;
    fill       = take && (!lat_vld || consume);
    drop       = take && lat_vld && !consume;
    fetch_rst  = direct ? vreset : lat_rst;
    fetch_addr = fetch_rst ? BASE : addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= BASE;
      lat_vld    <= 1'b0;
      lat_rst    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= BASE;
      vack       <= 1'b0;
      pixels_out <= 16'h0000;
      overrun    <= 1'b0;
    end else begin
      vack <= 1'b0;

      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;

      // A dropped request still contributes its frame restart.
      if (fill) begin
        lat_vld <= 1'b1;
        lat_rst <= vreset;
      end else if (drop) begin
        lat_rst <= lat_rst | vreset;
      end else if (consume) begin
        lat_vld <= 1'b0;
        lat_rst <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (direct || lat_vld) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state   <= DATA;
            mem_req <= 1'b0;
            addr    <= (mem_addr == LAST) ? BASE : mem_addr + ADDR_W'(1);
          end
        end
        DATA: begin
          state      <= ACK;
          pixels_out <= mem_rdata;
          vack       <= 1'b1;
        end
        ACK: begin
          if (lat_vld) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vga_dma.md
# vga_dma

Video DMA responder for the bilevel VGA controller. It services the controller's `vreq`/`vreset` word requests by fetching 16-bit frame-buffer words over the shared memory bus and returning them with a one-cycle `vack` strobe. It sits between the VGA controller and the memory arbiter. It owns the frame-buffer word address counter and flags any request it cannot service in time.

## Interface
Parameters:
- `ADDR_W`, default 16: word-address width.
- `BASE`, default 16'h0000: frame-buffer base word address.
- `FRAME_WORDS`, default 16380: words per frame (36 words/line × 455 lines).

Ports:
- `clk`  in  1: global clock.
- `rst_n`  in  1: global reset. One clock; reset is asynchronous and active-low.
- `vreq`  in  1: one-cycle word request from the VGA controller.
- `vreset`  in  1: asserted together with `vreq`. Restart the frame at `BASE`.
- `vack`  out  1: one-cycle strobe; `pixels_out` is valid this cycle.
- `pixels_out`  out  16: fetched word. Holds its value between strobes.
- `mem_req`  out  1: memory read request, held until granted.
- `mem_addr`  out  ADDR_W: word address, stable while `mem_req`=1.
- `mem_gnt`  in  1: arbiter grant; the read is accepted on the clock edge where `mem_req`&`mem_gnt`=1.
- `mem_rdata`  in  16: read data, valid in the cycle after the grant cycle.
- `ovr_clr`  in  1: synchronous clear of `overrun`.
- `overrun`  out  1: sticky flag; a request was dropped.

## Operation
- States:
  - IDLE: no fetch in progress.
  - REQ: `mem_req`=1, waiting for grant.
  - DATA: capture `mem_rdata`.
  - ACK: `vack`=1.
- Transitions:
  - IDLE→REQ when `vreq`=1, or when the latched request is set.
  - REQ→DATA on `mem_gnt`=1.
  - DATA→ACK unconditionally.
  - ACK→REQ if a latched request is pending; otherwise ACK→IDLE.
- Address counter `addr`, ADDR_W bits:
  - The fetch address is `BASE` if the request carried `vreset`. Otherwise it is `addr`.
  - On grant, `addr` ← fetch address + 1.
  - If fetch address = `BASE`+`FRAME_WORDS`−1, `addr` wraps to `BASE` instead. This guards against a missed `vreset`.
- Request latch (one deep): holds `vreq` and `vreset` that arrive while state≠IDLE, or while state=IDLE with the latch already set.
  - `vreq` while the latch is full: request dropped, `overrun`←1.
  - If the dropped request carried `vreset`, the latched entry's vreset bit is still OR-ed in, so frame restart is never lost.
- `vreq` in the same cycle the latch empties (ACK→REQ): the new request fills the latch. It is not dropped.
- `overrun` clears only on `ovr_clr`=1. If `ovr_clr` and a new drop occur in the same cycle, the set wins.
- `vreset` without `vreq` is ignored.
- Reset (`rst_n`=0, any state, including mid-fetch):
  - state=IDLE, latch empty, `addr`=`BASE`.
  - `mem_req`=0, `mem_addr`=`BASE`.
  - `vack`=0, `pixels_out`=16'h0000, `overrun`=0.
  - The in-flight bus cycle is abandoned. The arbiter sees `mem_req` drop asynchronously.

## Timing
- All outputs are registered. Cycle 0 is the cycle `vreq`=1 with state IDLE.
- Cycle 1: `mem_req`=1, `mem_addr`=fetch address.
- Grant in cycle g (g≥1) → `mem_rdata` sampled at end of g+1 → `vack`=1 and new `pixels_out` in cycle g+2.
  - Zero-wait latency `vreq`→`vack` is 3 cycles.
- The VGA controller issues `vreq` every 8 cycles and loads its shift register 8 cycles after the request. `vack` must therefore arrive by cycle 7, which leaves at most 4 wait cycles for the grant.
  - A longer grant is tolerated via the latch. A second late request sets `overrun`.
- Back-to-back from the latch: ACK at cycle n → `mem_req`=1 at n+1.
- `mem_req` deasserts the cycle after the grant cycle. `mem_addr` holds its value until the next request.

## Test plan
- Frame start: `vreq`+`vreset` with `mem_gnt` tied 1 → `mem_addr`=0x0000 at cycle 1, `vack` at cycle 3 with `pixels_out`=`mem_rdata`. Follow with a `vreq` every 8 cycles → addresses 0x0001, 0x0002, … in order.
- Wrap: issue 16381 requests without `vreset` → address sequence 0x3FFB (=`BASE`+`FRAME_WORDS`−1) then 0x0000.
- Grant stall: grant delayed 6 cycles, next `vreq` at cycle 8 → it is latched, `overrun`=0, two `vack`s with correct consecutive addresses. With a 14-cycle stall → the third request is dropped, `overrun`=1 until `ovr_clr`.
- Latched `vreset`: `vreq`+`vreset` arrives while a fetch is stalled in REQ → the next fetch uses address `BASE`, and the count continues from `BASE`+1.
- Reset mid-fetch: assert `rst_n`=0 during REQ → `mem_req`=0 immediately, `mem_addr`=0, `vack`=0, `pixels_out`=0, `overrun`=0. After release, the first `vreq` fetches `BASE`.
- Simultaneous `ovr_clr` and drop in the same cycle → `overrun` stays 1. `ovr_clr` alone → 0 next cycle.
